fast_frame_ctrl: RTL and testbench

Frame sequencer and corner buffer for the FAST + NMS corner pipeline. Accepts one greyscale frame as a valid/ready pixel stream, drives the pipeline's clock-enable and pixel input, and flushes the pipeline after the last pixel so that edge-row corners are emitted. Captures pipeline corner outputs into a FIFO and presents them as a valid/ready coordinate stream. Sits between the camera/DMA source and the downstream descriptor stage; wraps the existing FAST-with-NMS instance.

---
 rtl/fast_frame_ctrl_if.sv | 23 ++
 rtl/fast_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fast_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fast_frame_ctrl_if.sv
// Pixel-in and corner-out valid/ready streams of the FAST frame controller.
// The master modport is the source/sink side; slave is the controller.
interface fast_frame_ctrl_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   pix_valid;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_ready;
    logic                   crn_valid;
    logic                   crn_ready;
    logic [9:0]             crn_x;
    logic [9:0]             crn_y;

    modport master (
        output pix_valid, pix_data, crn_ready,
        input  pix_ready, crn_valid, crn_x, crn_y
    );

    modport slave (
        input  pix_valid, pix_data, crn_ready,
        output pix_ready, crn_valid, crn_x, crn_y
    );
endinterface

// File: rtl/fast_frame_ctrl.sv
// Frame sequencer and corner FIFO wrapped around the FAST+NMS pipeline.
// Optional per-frame corner cap is enabled by defining FAST_CORNER_LIMIT_EN.
module fast_frame_ctrl #(
    parameter int COL_NUM      = 640,
    parameter int ROW_NUM      = 480,
    parameter int PIXEL_WIDTH  = 8,
    parameter int FLUSH_CYCLES = 2576,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_CORNERS  = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    fast_frame_ctrl_if.slave       bus,
    output logic                   fast_ce,
    output logic [PIXEL_WIDTH-1:0] fast_data,
    input  logic                   fast_iscorner,
    input  logic [9:0]             fast_x,
    input  logic [9:0]             fast_y,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            corner_count,
    output logic                   limit_hit
);

    localparam int PIX_TOTAL = COL_NUM * ROW_NUM;
    localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
    localparam int FLUSH_W   = $clog2(FLUSH_CYCLES + 1);
    localparam int ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = ADDR_W + 1;

    // state | meaning
    // IDLE  | waiting for start, pipeline clock gated
    // RUN   | forwarding source pixels to the pipeline
    // FLUSH | feeding zero pixels so edge-row corners come out
    // DRAIN | waiting for the corner FIFO to empty
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t             state;
    logic [PIX_W-1:0]   pix_cnt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [19:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic has_room;
    logic accept;
    logic corner_seen;
    logic push;
    logic pop;
    logic crn_valid_int;

    assign has_room      = fifo_count <= CNT_W'(FIFO_DEPTH - 2);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign corner_seen   = fast_ce && fast_iscorner;
    assign crn_valid_int = fifo_count != '0;
    assign pop           = crn_valid_int && bus.crn_ready;

    assign bus.pix_ready = (state == RUN) && has_room;
    assign bus.crn_valid = crn_valid_int;
    assign bus.crn_x     = crn_valid_int ? mem[rd_ptr][19:10] : '0;
    assign bus.crn_y     = crn_valid_int ? mem[rd_ptr][9:0]   : '0;
    assign busy          = state != IDLE;

`ifdef FAST_CORNER_LIMIT_EN
    logic at_cap;
    assign at_cap = corner_count == 16'(MAX_CORNERS);
    assign push   = corner_seen && !at_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            limit_hit <= 1'b0;
        end else if (state == IDLE && start) begin
            limit_hit <= 1'b0;
        end else if (corner_seen && at_cap) begin
            limit_hit <= 1'b1;
        end
    end
`else
    assign push      = corner_seen;
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            flush_cnt  <= '0;
            fast_ce    <= 1'b0;
            fast_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            fast_ce    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        pix_cnt   <= '0;
                        flush_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        fast_ce   <= 1'b1;
                        fast_data <= bus.pix_data;
                        pix_cnt   <= pix_cnt + PIX_W'(1);
                        if (pix_cnt == PIX_W'(PIX_TOTAL - 1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (has_room) begin
                        fast_ce   <= 1'b1;
                        fast_data <= '0;
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                        if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last flush pixel can still yield a corner on the first DRAIN edge.
                    if (fifo_count == '0 && !push) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corner_count <= '0;
        end else if (state == IDLE && start) begin
            corner_count <= '0;
        end else if (push && corner_count != 16'hFFFF) begin
            corner_count <= corner_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {fast_x, fast_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// Directed bench for fast_frame_ctrl: table of frame scenarios plus reset/abort sequences.
`timescale 1ns/1ps
module tb_fast_frame_ctrl;
    localparam int COL   = 8;
    localparam int ROW   = 4;
    localparam int FLUSH = 5;
    localparam int DEPTH = 4;
    localparam int MAXC  = 3;
    localparam int PW    = 8;
    localparam int NPIX  = COL * ROW;
    localparam int NCE   = NPIX + FLUSH;
`ifdef FAST_CORNER_LIMIT_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fast_ce;
    logic [PW-1:0] fast_data;
    logic          fast_iscorner;
    logic [9:0]    fast_x;
    logic [9:0]    fast_y;
    logic          busy;
    logic          frame_done;
    logic [15:0]   corner_count;
    logic          limit_hit;

    fast_frame_ctrl_if #(.PIXEL_WIDTH(PW)) bus ();

    fast_frame_ctrl #(
        .COL_NUM(COL), .ROW_NUM(ROW), .PIXEL_WIDTH(PW),
        .FLUSH_CYCLES(FLUSH), .FIFO_DEPTH(DEPTH), .MAX_CORNERS(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .fast_ce(fast_ce), .fast_data(fast_data),
        .fast_iscorner(fast_iscorner), .fast_x(fast_x), .fast_y(fast_y),
        .busy(busy), .frame_done(frame_done),
        .corner_count(corner_count), .limit_hit(limit_hit)
    );

    always #5 clk = ~clk;

    // Stand-in pipeline: a corner flag and coordinates keyed by the index of the enabled cycle.
    int          ce_idx = 0;
    logic [63:0] mask = '0;
    always @(posedge clk) begin
        if (start && !busy) ce_idx <= 0;
        else if (fast_ce)   ce_idx <= ce_idx + 1;
    end
    assign fast_iscorner = fast_ce && (ce_idx < 64) && mask[ce_idx[5:0]];
    assign fast_x        = 10'(ce_idx);
    assign fast_y        = 10'(ce_idx * 3 + 1);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame monitor, sampled on the falling edge.
    bit         mon_en = 1'b0;
    int         acc_cnt, ce_cnt, flush_m, order_bad, mirror_bad, ready_bad, valid_bad, occ_bad;
    int         model_cnt, model_cc;
    logic       prev_acc;
    logic [7:0] dq[$];
    logic [19:0] pq[$];

    always @(negedge clk) begin : mon
        logic acc, pu, po;
        if (mon_en) begin
            acc = bus.pix_valid && bus.pix_ready;
            if (fast_ce) begin
                ce_cnt++;
                if (prev_acc) begin
                    if (dq.size() == 0 || fast_data != dq[0]) order_bad++;
                    if (dq.size() != 0) void'(dq.pop_front());
                end else begin
                    flush_m++;
                    if (fast_data != '0) order_bad++;
                end
            end else if (prev_acc) begin
                mirror_bad++;
            end
            if (acc) dq.push_back(bus.pix_data);
            prev_acc = acc;
            if (busy && acc_cnt < NPIX) begin
                if (bus.pix_ready != (model_cnt <= DEPTH - 2)) ready_bad++;
            end else if (bus.pix_ready) begin
                ready_bad++;
            end
            if (bus.crn_valid != (model_cnt != 0)) valid_bad++;
            pu = fast_iscorner && (!CAP_EN || model_cc < MAXC);
            po = bus.crn_valid && bus.crn_ready;
            if (po) pq.push_back({bus.crn_x, bus.crn_y});
            model_cnt = model_cnt + int'(pu) - int'(po);
            model_cc  = model_cc + int'(pu);
            if (model_cnt > DEPTH) occ_bad++;
            if (acc) acc_cnt++;
        end
    end

    typedef struct {
        string       name;
        bit          toggle;
        logic [63:0] mask;
        int          ready_delay;
        int          restart_at;
        int          ncorn;
        int          exp_done;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int cyc, ncap, nbad, k, busy_bad;
        logic [19:0] e;
        acc_cnt = 0; ce_cnt = 0; flush_m = 0; order_bad = 0; mirror_bad = 0;
        ready_bad = 0; valid_bad = 0; occ_bad = 0; model_cnt = 0; model_cc = 0;
        prev_acc = 1'b0; dq.delete(); pq.delete();
        mask = v.mask;
        busy_bad = 0;
        mon_en = 1'b1;
        start = 1'b1;
        bus.pix_valid = 1'b0;
        bus.crn_ready = (v.ready_delay == 0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 2000) begin
            if (!busy) busy_bad++;
            bus.pix_valid = v.toggle ? cyc[0] : 1'b1;
            bus.pix_data  = 8'(acc_cnt + 1);
            bus.crn_ready = (cyc >= v.ready_delay);
            start         = (cyc == v.restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        check({v.name, "_timeout"}, 64'(cyc >= 2000), 0);
        if (v.exp_done != 0) check({v.name, "_done_cycle"}, cyc, v.exp_done);
        check({v.name, "_busy_held"}, busy_bad, 0);
        @(negedge clk);
        @(posedge clk); #1;
        mon_en = 1'b0;
        check({v.name, "_done_pulse"}, frame_done, 0);
        check({v.name, "_busy_after"}, busy, 0);
        check({v.name, "_accepts"}, acc_cnt, NPIX);
        check({v.name, "_ce_cycles"}, ce_cnt, NCE);
        check({v.name, "_flush_cycles"}, flush_m, FLUSH);
        check({v.name, "_data_order"}, order_bad, 0);
        check({v.name, "_ce_mirror"}, mirror_bad, 0);
        check({v.name, "_pix_ready"}, ready_bad, 0);
        check({v.name, "_crn_valid"}, valid_bad, 0);
        check({v.name, "_occupancy"}, occ_bad, 0);
        ncap = (CAP_EN && v.ncorn > MAXC) ? MAXC : v.ncorn;
        nbad = 0;
        k = 0;
        for (int i = 0; i < NCE; i++) begin
            if (v.mask[i] && k < ncap) begin
                e = {10'(i), 10'(i * 3 + 1)};
                if (k >= pq.size() || pq[k] != e) nbad++;
                k++;
            end
        end
        check({v.name, "_emit_order"}, nbad, 0);
        check({v.name, "_emit_count"}, pq.size(), ncap);
        check({v.name, "_corner_count"}, corner_count, ncap);
        check({v.name, "_limit_hit"}, limit_hit, 64'(CAP_EN && v.ncorn > MAXC));
    endtask

    vec_t vecs[5];

    initial begin
        int cyc;
        vecs[0] = '{"clean",    1'b0, 64'h0,            0,  0, 0,  39};
        vecs[1] = '{"backpress",1'b0, 64'h1F_FFFF_FFFF, 60, 0, 37, 0};
        vecs[2] = '{"cap",      1'b0, 64'h10_4002_0208, 0,  0, 5,  0};
        vecs[3] = '{"toggle",   1'b1, 64'h22,           0,  0, 2,  70};
        vecs[4] = '{"restart",  1'b0, 64'h0,            0,  10, 0, 39};

        rst = 1'b1; start = 1'b0;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.crn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_fast_ce", fast_ce, 0);
        check("rst_fast_data", fast_data, 0);
        check("rst_crn_valid", bus.crn_valid, 0);
        check("rst_crn_x", bus.crn_x, 0);
        check("rst_crn_y", bus.crn_y, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_corner_count", corner_count, 0);
        check("rst_limit_hit", limit_hit, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Abort in FLUSH with two corners held in the FIFO.
        mask = 64'hC000_0000;
        bus.crn_ready = 1'b0;
        bus.pix_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 35) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.pix_valid = 1'b0;
        check("abort_pre_busy", busy, 1);
        check("abort_pre_crn_valid", bus.crn_valid, 1);
        check("abort_pre_pix_ready", bus.pix_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_crn_valid", bus.crn_valid, 0);
        check("abort_fast_ce", fast_ce, 0);
        check("abort_corner_count", corner_count, 0);
        check("abort_crn_x", bus.crn_x, 0);
        bus.crn_ready = 1'b1;
        @(posedge clk); #1;
        check("abort_stays_empty", bus.crn_valid, 0);
        check("abort_stays_idle", busy, 0);

        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
